// File: rtl/slug_uart.sv
// ---------------------------------------------------------------------------
// slug_uart
//   Serial I/O bridge between the slug CPU port registers and an 8N1 UART.
//   All CPU handshakes are level toggles, so the CPU may poll with any
//   latency. The bit time is fixed at CLK_DIV clock cycles.
//
// Parameters:
//   CLK_DIV  clock cycles per serial bit (4..65535)
//   CNT_W    width of the baud counters (CLK_DIV < 2**CNT_W)
//
// Ports:
//   clk       system clock, shared with the CPU
//   rst       asynchronous active-low reset
//   port_out  CPU output port: [7:0] TX byte, [8] tx_req toggle,
//             [9] rx_ack toggle, [31:10] ignored
//   port_in   CPU input port: [7:0] RX byte, [8] tx_ack toggle,
//             [9] rx_rdy toggle, [10] overrun, [11] frame error, rest 0
//   uart_rx   serial line in, asynchronous to clk
//   uart_tx   serial line out, idle high
//
// Build option:
//   SLUG_UART_RX_FIFO_EN  when defined, the single RX holding register is
//                         replaced by a 4-entry FIFO.
// ---------------------------------------------------------------------------
module slug_uart #(
    parameter int CLK_DIV = 16,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] port_out,
    output logic [31:0] port_in,
    input  logic        uart_rx,
    output logic        uart_tx
);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    uart_state_t      tx_state, tx_state_next;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_next;
    logic [2:0]       tx_bit, tx_bit_next;
    logic [7:0]       tx_shift, tx_shift_next;
    logic             tx_ack, tx_ack_next;
    logic             tx_line_next;
    logic             tx_bit_end;

    assign tx_bit_end = (tx_cnt == BIT_LAST);

    // uart_tx is registered so the line never glitches; it is computed from
    // the next state so the start bit still falls one cycle after the request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_ack   <= 1'b0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            tx_cnt   <= tx_cnt_next;
            tx_bit   <= tx_bit_next;
            tx_shift <= tx_shift_next;
            tx_ack   <= tx_ack_next;
            uart_tx  <= tx_line_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state;
        tx_cnt_next   = tx_cnt;
        tx_bit_next   = tx_bit;
        tx_shift_next = tx_shift;
        tx_ack_next   = tx_ack;
        tx_line_next  = 1'b1;
        case (tx_state)
            IDLE: begin
                if (port_out[8] != tx_ack) begin
                    tx_shift_next = port_out[7:0];
                    tx_cnt_next   = '0;
                    tx_state_next = START;
                end
            end
            START: begin
                if (tx_bit_end) begin
                    tx_cnt_next   = '0;
                    tx_bit_next   = '0;
                    tx_state_next = DATA;
                end else begin
                    tx_cnt_next = tx_cnt + CNT_ONE;
                end
            end
            DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_next   = '0;
                    tx_shift_next = {1'b0, tx_shift[7:1]};
                    tx_bit_next   = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) begin
                        tx_state_next = STOP;
                    end
                end else begin
                    tx_cnt_next = tx_cnt + CNT_ONE;
                end
            end
            STOP: begin
                if (tx_bit_end) begin
                    tx_cnt_next   = '0;
                    tx_ack_next   = ~tx_ack;
                    tx_state_next = IDLE;
                end else begin
                    tx_cnt_next = tx_cnt + CNT_ONE;
                end
            end
            default: tx_state_next = IDLE;
        endcase
        case (tx_state_next)
            START:   tx_line_next = 1'b0;
            DATA:    tx_line_next = tx_shift_next[0];
            default: tx_line_next = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic             rx_meta, rx_sync, rx_prev;
    uart_state_t      rx_state, rx_state_next;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_next;
    logic [2:0]       rx_bit, rx_bit_next;
    logic [7:0]       rx_shift, rx_shift_next;
    logic             rx_done_ok, rx_done_bad;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection;
    // all reset high so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_meta  <= uart_rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_state_next;
            rx_cnt   <= rx_cnt_next;
            rx_bit   <= rx_bit_next;
            rx_shift <= rx_shift_next;
        end
    end

    // The start bit is rechecked half a bit after the falling edge so that
    // short glitches are rejected and later samples land mid-bit.
    always_comb begin
        rx_state_next = rx_state;
        rx_cnt_next   = rx_cnt;
        rx_bit_next   = rx_bit;
        rx_shift_next = rx_shift;
        rx_done_ok    = 1'b0;
        rx_done_bad   = 1'b0;
        case (rx_state)
            IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_cnt_next   = '0;
                    rx_state_next = START;
                end
            end
            START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_next = '0;
                    rx_bit_next = '0;
                    rx_state_next = rx_sync ? IDLE : DATA;
                end else begin
                    rx_cnt_next = rx_cnt + CNT_ONE;
                end
            end
            DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_sync, rx_shift[7:1]};
                    rx_bit_next   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) begin
                        rx_state_next = STOP;
                    end
                end else begin
                    rx_cnt_next = rx_cnt + CNT_ONE;
                end
            end
            STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_state_next = IDLE;
                    rx_done_ok    = rx_sync;
                    rx_done_bad   = !rx_sync;
                end else begin
                    rx_cnt_next = rx_cnt + CNT_ONE;
                end
            end
            default: rx_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // RX hand-off to the CPU
    // ------------------------------------------------------------------
    logic       ack_q;
    logic       ack_event;
    logic       rx_drop;
    logic       rx_rdy;
    logic [7:0] rx_head;
    logic       overrun, frame_err;

    assign ack_event = (port_out[9] != ack_q);

    // Any ack toggle clears the sticky error flags; a new error in the same
    // cycle wins so it is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ack_q <= port_out[9];
            if (rx_drop) begin
                overrun <= 1'b1;
            end else if (ack_event) begin
                overrun <= 1'b0;
            end
            if (rx_done_bad) begin
                frame_err <= 1'b1;
            end else if (ack_event) begin
                frame_err <= 1'b0;
            end
        end
    end

`ifdef SLUG_UART_RX_FIFO_EN
    logic [7:0] fifo_mem [4];
    logic [1:0] rd_ptr, wr_ptr;
    logic [2:0] fifo_count;
    logic [2:0] count_after_pop;
    logic       head_shown;
    logic       fifo_pop, fifo_push;

    assign fifo_pop        = ack_event && head_shown;
    assign count_after_pop = fifo_count - {2'b00, fifo_pop};
    assign fifo_push       = rx_done_ok && (count_after_pop != 3'd4);
    assign rx_drop         = rx_done_ok && (count_after_pop == 3'd4);
    assign rx_head         = fifo_mem[rd_ptr];

    // head_shown marks that rx_rdy has already been toggled for the current
    // head. After a pop the next head is announced one cycle later; an empty
    // FIFO announces a new byte in the same cycle it is written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= '0;
            end
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            head_shown <= 1'b0;
            rx_rdy     <= 1'b0;
        end else begin
            if (fifo_push) begin
                fifo_mem[wr_ptr] <= rx_shift;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            fifo_count <= count_after_pop + {2'b00, fifo_push};
            if (fifo_pop) begin
                head_shown <= 1'b0;
            end else if (!head_shown && (fifo_count != 3'd0 || fifo_push)) begin
                head_shown <= 1'b1;
                rx_rdy     <= ~rx_rdy;
            end
        end
    end
`else
    logic rx_full;
    logic rx_load;

    // Occupancy is tracked internally so a stray ack on an empty buffer only
    // clears flags. An ack in the delivery cycle frees the slot first.
    assign rx_load = rx_done_ok && (!rx_full || ack_event);
    assign rx_drop = rx_done_ok && rx_full && !ack_event;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_full <= 1'b0;
            rx_rdy  <= 1'b0;
            rx_head <= '0;
        end else begin
            if (rx_load) begin
                rx_head <= rx_shift;
                rx_rdy  <= ~rx_rdy;
                rx_full <= 1'b1;
            end else if (ack_event) begin
                rx_full <= 1'b0;
            end
        end
    end
`endif

    logic unused_port_bits;
    assign unused_port_bits = &{1'b0, port_out[31:10]};

    assign port_in = {20'd0, frame_err, overrun, rx_rdy, tx_ack, rx_head};

endmodule
